// File: rtl/mem_bridge.sv
// mem_bridge: single-port bridge from a RISC-V style load/store request
// interface to a synchronous word RAM and a small memory-mapped I/O block
// (LED register and switch inputs). Addresses at or above IO_BASE go to I/O.
module mem_bridge #(
   parameter logic [31:0] IO_BASE = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic [31:0] io_led,
   input  logic [31:0] io_sw
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_led;

   logic        w_accept;
   logic        w_is_io;
   logic [31:0] w_io_off;
   logic        w_req_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [3:0]  w_be;
   logic [31:0] w_rep_wdata;

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_is_io  = (req_addr >= IO_BASE);
   assign w_io_off = req_addr - IO_BASE;

   // Request legality: size code, store size, alignment and I/O map checks.
   always_comb begin
      w_req_err = 1'b0;
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
         w_req_err = 1'b1;
      if (req_we && (req_funct3 > 3'b010))
         w_req_err = 1'b1;
      if ((req_funct3[1:0] == 2'b01) && req_addr[0])
         w_req_err = 1'b1;
      if ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00))
         w_req_err = 1'b1;
      if (w_is_io && ((req_funct3 != 3'b010) ||
                      ((w_io_off != 32'd0) && (w_io_off != 32'd4))))
         w_req_err = 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // FSM next-state: errors and I/O answer directly, RAM goes through ACCESS/WAIT.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_req_err || w_is_io) w_next = S_RESP;
               else                      w_next = S_ACCESS;
            end
         end
         S_ACCESS: w_next = S_WAIT;
         S_WAIT:   w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request capture, I/O side effects and response data registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         r_led    <= '0;
      end else begin
         if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            if (w_req_err) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end else if (w_is_io) begin
               r_err <= 1'b0;
               if (req_we) begin
                  r_rdata <= '0;
                  if (w_io_off == 32'd0) r_led <= req_wdata;
               end else begin
                  r_rdata <= (w_io_off == 32'd0) ? r_led : io_sw;
               end
            end
         end
         if (r_state == S_WAIT) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : w_load_data;
         end
      end
   end

   // Load lane selection and sign/zero extension of the RAM read word.
   always_comb begin
      w_byte = '0;
      case (r_addr[1:0])
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      w_be        = 4'b1111;
      w_rep_wdata = r_wdata;
      if (r_we) begin
         case (r_funct3)
            3'b000: begin
               w_be        = 4'b0001 << r_addr[1:0];
               w_rep_wdata = {4{r_wdata[7:0]}};
            end
            3'b001: begin
               w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
               w_rep_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
               w_be        = 4'b1111;
               w_rep_wdata = r_wdata;
            end
         endcase
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   assign io_led     = r_led;
   assign mem_addr   = (r_state == S_ACCESS) ? r_addr[31:2] : '0;
   assign mem_wdata  = (r_state == S_ACCESS) ? w_rep_wdata  : '0;
   assign mem_be     = (r_state == S_ACCESS) ? w_be         : '0;
   assign mem_we     = (r_state == S_ACCESS) && r_we;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed vector table, reset-abort sequence and random
// requests checked against a byte-level reference model of RAM and I/O.
module tb_mem_bridge;

   localparam logic [31:0] IO_BASE = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [31:0] io_led;
   logic [31:0] io_sw;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bridge #(.IO_BASE(IO_BASE)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .io_led(io_led), .io_sw(io_sw)
   );

   always #5 clk = ~clk;

   // Physical RAM stand-in: 64 words, synchronous read, byte-enabled write.
   logic [31:0] ram [64];
   always @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) ram[mem_addr[5:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      mem_rdata <= ram[mem_addr[5:0]];
   end

   // Reference model state: byte-addressed RAM image and LED register.
   logic [7:0]  ref_mem [256];
   logic [31:0] ref_led;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Spec-level model of one request: returns the response and side effects.
   task automatic ref_apply(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic [2:0] f3, input logic [31:0] sw,
                            output logic [31:0] rd, output logic err, output int lat,
                            output logic [3:0] be);
      logic bad;
      logic is_io;
      logic [31:0] off;
      int size;
      logic [31:0] v;
      bad = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 > 2) ||
            ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && (addr % 4) != 0);
      is_io = (addr >= IO_BASE);
      off = addr - IO_BASE;
      if (is_io && (f3 != 2 || (off != 0 && off != 4))) bad = 1'b1;
      rd = 0; err = 0; lat = 1; be = 4'b0000;
      if (bad) begin
         err = 1'b1;
      end else if (is_io) begin
         if (we) begin
            if (off == 0) ref_led = wdata;
         end else begin
            rd = (off == 0) ? ref_led : sw;
         end
      end else begin
         lat = 3;
         size = 1 << (f3 % 4);
         if (we) begin
            be = 4'(((1 << size) - 1) << (addr % 4));
            for (int i = 0; i < size; i++) ref_mem[(addr + i) % 256] = wdata[8*i +: 8];
         end else begin
            be = 4'b1111;
            v = 0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(addr + i) % 256];
            if (f3 < 4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
         end
      end
   endtask

   // Issue one request; while busy, drive junk requests that must be ignored.
   task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [2:0] f3, input logic [31:0] sw,
                         output logic [31:0] rd, output logic err, output int lat,
                         output logic [3:0] be1, output logic [31:0] wd1,
                         output logic [29:0] ma1, output int wecnt, output logic hold_ok);
      @(negedge clk);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we;
      req_funct3 = f3; io_sw = sw;
      @(posedge clk);
      #1;
      req_valid = 1'($urandom % 2); req_addr = IO_BASE; req_we = 1'b1;
      req_funct3 = 3'b010; req_wdata = $urandom; io_sw = $urandom;
      rd = 0; err = 0; lat = 0; be1 = 0; wd1 = 0; ma1 = 0; wecnt = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_we) wecnt++;
         if (c == 1) begin be1 = mem_be; wd1 = mem_wdata; ma1 = mem_addr; end
         if (resp_valid) begin lat = c; rd = resp_rdata; err = resp_err; break; end
      end
      req_valid = 1'b0;
      @(negedge clk);
      hold_ok = !resp_valid && (resp_rdata === rd) && (resp_err === err);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata,          32'd0);
      chk({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
      chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
      chk({tag, "_mem_be"},     {28'd0, mem_be},     32'd0);
      chk({tag, "_mem_addr"},   {2'd0, mem_addr},    32'd0);
      chk({tag, "_mem_wdata"},  mem_wdata,           32'd0);
      chk({tag, "_io_led"},     io_led,              32'd0);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] sw;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_led;
   } vec_t;

   vec_t vecs [22];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mrd, wexp, mask;
      logic err, merr, hold_ok;
      int lat, mlat, wecnt;
      logic [3:0] be1, mbe;
      logic [31:0] wd1;
      logic [29:0] ma1;
      logic [31:0] a, wd, sw;
      logic we;
      logic [2:0] f3;
      int sel;

      //             addr             wdata         we  f3      sw     exp_rd        err lat be       exp_wd        led
      vecs[0]  = '{32'h0000_0008, 32'h0,        0, 3'b010, 32'h0,  32'h8899_AABB, 0, 3, 4'b1111, 32'h0,        32'h0};
      vecs[1]  = '{32'h0000_0007, 32'h0,        0, 3'b000, 32'h0,  32'hFFFF_FF80, 0, 3, 4'b1111, 32'h0,        32'h0};
      vecs[2]  = '{32'h0000_0007, 32'h0,        0, 3'b100, 32'h0,  32'h0000_0080, 0, 3, 4'b1111, 32'h0,        32'h0};
      vecs[3]  = '{32'h0000_0006, 32'h0000_BEEF,1, 3'b001, 32'h0,  32'h0,         0, 3, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      vecs[4]  = '{32'h0000_0006, 32'h0,        0, 3'b101, 32'h0,  32'h0000_BEEF, 0, 3, 4'b1111, 32'h0,        32'h0};
      vecs[5]  = '{32'h0000_0002, 32'h0,        0, 3'b010, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'h0};
      vecs[6]  = '{32'h0000_0000, 32'h0,        0, 3'b011, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'h0};
      vecs[7]  = '{IO_BASE,       32'h0000_00A5,1, 3'b010, 32'h0,  32'h0,         0, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[8]  = '{IO_BASE + 4,   32'h0,        0, 3'b010, 32'h3C, 32'h0000_003C, 0, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[9]  = '{IO_BASE,       32'h0,        0, 3'b000, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[10] = '{32'hFFFF_FFFF, 32'h0,        0, 3'b010, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[11] = '{IO_BASE + 8,   32'h0,        0, 3'b010, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[12] = '{32'h0000_0009, 32'h1234_5677,1, 3'b000, 32'h0,  32'h0,         0, 3, 4'b0010, 32'h7777_7777, 32'hA5};
      vecs[13] = '{32'h0000_0008, 32'h0,        0, 3'b001, 32'h0,  32'h0000_77BB, 0, 3, 4'b1111, 32'h0,        32'hA5};
      vecs[14] = '{32'h0000_000A, 32'h0,        0, 3'b001, 32'h0,  32'hFFFF_8899, 0, 3, 4'b1111, 32'h0,        32'hA5};
      vecs[15] = '{IO_BASE + 4,   32'hFFFF_FFFF,1, 3'b010, 32'h0,  32'h0,         0, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[16] = '{IO_BASE,       32'h0,        0, 3'b010, 32'h0,  32'h0000_00A5, 0, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[17] = '{32'h0000_0000, 32'h1,        1, 3'b100, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[18] = '{32'h0000_0005, 32'h1,        0, 3'b001, 32'h0,  32'h0,         1, 1, 4'b0000, 32'h0,        32'hA5};
      vecs[19] = '{32'h0000_0010, 32'hDEAD_BEEF,1, 3'b010, 32'h0,  32'h0,         0, 3, 4'b1111, 32'hDEAD_BEEF, 32'hA5};
      vecs[20] = '{32'h0000_0010, 32'h0,        0, 3'b010, 32'h0,  32'hDEAD_BEEF, 0, 3, 4'b1111, 32'h0,        32'hA5};
      vecs[21] = '{32'h0000_0008, 32'h0,        0, 3'b000, 32'h0,  32'hFFFF_FFBB, 0, 3, 4'b1111, 32'h0,        32'hA5};

      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      ram[1] = 32'h80FF_1234;
      ram[2] = 32'h8899_AABB;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram[i / 4][8 * (i % 4) +: 8];
      ref_led = 0;

      resetn = 1'b0; req_valid = 1'b0; req_addr = 0; req_wdata = 0;
      req_we = 1'b0; req_funct3 = 0; io_sw = 0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // Directed vectors with hand-derived expectations.
      for (int i = 0; i < 22; i++) begin
         do_req(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].f3, vecs[i].sw,
                rd, err, lat, be1, wd1, ma1, wecnt, hold_ok);
         ref_apply(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].f3, vecs[i].sw,
                   mrd, merr, mlat, mbe);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_be", i), {28'd0, be1}, {28'd0, vecs[i].exp_be});
         chk($sformatf("v%0d_we_cycles", i), wecnt,
             (vecs[i].we && vecs[i].exp_lat == 3) ? 1 : 0);
         chk($sformatf("v%0d_hold", i), {31'd0, hold_ok}, 32'd1);
         chk($sformatf("v%0d_io_led", i), io_led, vecs[i].exp_led);
         if (vecs[i].exp_lat == 3)
            chk($sformatf("v%0d_mem_addr", i), {2'd0, ma1}, {2'd0, vecs[i].addr[31:2]});
         if (vecs[i].we && vecs[i].exp_lat == 3)
            chk($sformatf("v%0d_mem_wdata", i), wd1, vecs[i].exp_wd);
      end

      // Reset asserted while a load sits in WAIT: immediate reset values, no pulse.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_0010; req_we = 1'b0; req_funct3 = 3'b010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_outputs("abort");
      ref_led = 0;
      wecnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid) wecnt++;
      end
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid) wecnt++;
      end
      chk("abort_no_resp_pulse", wecnt, 0);
      chk("abort_ready_after_release", {31'd0, req_ready}, 32'd1);

      // Random requests against the reference model.
      for (int n = 0; n < 400; n++) begin
         sel = $urandom % 8;
         if (sel < 5)       a = $urandom % 256;
         else if (sel < 7)  a = IO_BASE + 4 * ($urandom % 3);
         else if ($urandom % 2 == 1) a = 32'hFFFF_FFFF;
         else               a = IO_BASE + ($urandom % 12);
         we = 1'($urandom % 2);
         if ($urandom % 8 == 0)  f3 = 3'($urandom);
         else if (sel >= 5)      f3 = 3'b010;
         else begin
            case ($urandom % 5)
               0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         if (f3 == 3'b010 && sel < 5 && $urandom % 4 != 0) a = a & ~32'd3;
         if (f3[1:0] == 2'b01 && $urandom % 4 != 0) a = a & ~32'd1;
         wd = $urandom; sw = $urandom;
         do_req(a, wd, we, f3, sw, rd, err, lat, be1, wd1, ma1, wecnt, hold_ok);
         ref_apply(a, wd, we, f3, sw, mrd, merr, mlat, mbe);
         chk("rnd_latency", lat, mlat);
         chk("rnd_rdata", rd, mrd);
         chk("rnd_err", {31'd0, err}, {31'd0, merr});
         chk("rnd_be", {28'd0, be1}, {28'd0, mbe});
         chk("rnd_we_cycles", wecnt, (we && mlat == 3) ? 1 : 0);
         chk("rnd_hold", {31'd0, hold_ok}, 32'd1);
         chk("rnd_io_led", io_led, ref_led);
         if (mlat == 3) chk("rnd_mem_addr", {2'd0, ma1}, {2'd0, a[31:2]});
         if (we && mlat == 3) begin
            wexp = 0; mask = 0;
            for (int i = 0; i < 4; i++) begin
               wexp[8*i +: 8] = ref_mem[(a & 32'hFC) + i];
               if (mbe[i]) mask[8*i +: 8] = 8'hFF;
            end
            chk("rnd_mem_wdata_lanes", wd1 & mask, wexp & mask);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
